// File: rtl/cfg_bus_arb.sv
// cfg_bus_arb: round-robin arbiter funnelling N upstream cfg requesters onto
// one downstream cfg port, with a per-transaction downstream timeout.
module cfg_bus_arb #(
  parameter int unsigned N_PORTS       = 4,
  parameter int unsigned TIMEOUT_CYC   = 256,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic [N_PORTS*32-1:0] up_addr,
  input  logic [N_PORTS*32-1:0] up_wdata,
  input  logic [N_PORTS-1:0]    up_wr,
  input  logic [N_PORTS-1:0]    up_rd,
  output logic [N_PORTS-1:0]    up_ack,
  output logic [N_PORTS*32-1:0] up_rdata,
  output logic [31:0]           dn_addr,
  output logic [31:0]           dn_wdata,
  output logic                  dn_wr,
  output logic                  dn_rd,
  input  logic                  dn_ack,
  input  logic [31:0]           dn_rdata,
  input  logic                  timeout_clr,
  output logic                  timeout_sticky,
  output logic [15:0]           timeout_cnt
);

  localparam int unsigned PW        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic                  op_wr_q, op_wr_d;
  logic [31:0]           dn_addr_q, dn_addr_d;
  logic [31:0]           dn_wdata_q, dn_wdata_d;
  logic                  dn_wr_q, dn_wr_d;
  logic                  dn_rd_q, dn_rd_d;
  logic [N_PORTS-1:0]    up_ack_q, up_ack_d;
  logic [N_PORTS*32-1:0] up_rdata_q, up_rdata_d;
  logic [15:0]           wait_q, wait_d;
  logic                  sticky_q, sticky_d;
  logic [15:0]           tcnt_q, tcnt_d;

  logic [N_PORTS-1:0]    req;
  logic                  found;
  logic [PW-1:0]         pick;
  int unsigned           idx;

  // Round-robin pick: first requester at or after the port following the last grant.
  always_comb begin
    req   = up_wr | up_rd;
    found = 1'b0;
    pick  = grant_q;
    idx   = 0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      idx = (32'(grant_q) + i) % N_PORTS;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/ISSUE/RESP FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    op_wr_d    = op_wr_q;
    dn_addr_d  = dn_addr_q;
    dn_wdata_d = dn_wdata_q;
    dn_wr_d    = dn_wr_q;
    dn_rd_d    = dn_rd_q;
    up_ack_d   = '0;
    up_rdata_d = up_rdata_q;
    wait_d     = wait_q;
    sticky_d   = sticky_q;
    tcnt_d     = tcnt_q;

    // Clear is applied first so a timeout in the same cycle overrides it.
    if (timeout_clr) begin
      sticky_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d    = pick;
          op_wr_d    = up_wr[pick];
          dn_addr_d  = up_addr[32*int'(pick) +: 32];
          dn_wdata_d = up_wdata[32*int'(pick) +: 32];
          // A port raising both wr and rd gets a write only.
          dn_wr_d    = up_wr[pick];
          dn_rd_d    = ~up_wr[pick];
          wait_d     = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dn_ack) begin
          dn_wr_d   = 1'b0;
          dn_rd_d   = 1'b0;
          up_ack_d[grant_q] = 1'b1;
          up_rdata_d[32*int'(grant_q) +: 32] = op_wr_q ? '0 : dn_rdata;
          state_d   = S_RESP;
        end else if (wait_q == WAIT_LAST) begin
          dn_wr_d   = 1'b0;
          dn_rd_d   = 1'b0;
          up_ack_d[grant_q] = 1'b1;
          up_rdata_d[32*int'(grant_q) +: 32] = TIMEOUT_RDATA;
          sticky_d  = 1'b1;
          if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 16'd1;
          end
          state_d   = S_RESP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q    <= S_IDLE;
      grant_q    <= PW'(N_PORTS - 1);
      op_wr_q    <= 1'b0;
      dn_addr_q  <= '0;
      dn_wdata_q <= '0;
      dn_wr_q    <= 1'b0;
      dn_rd_q    <= 1'b0;
      up_ack_q   <= '0;
      up_rdata_q <= '0;
      wait_q     <= '0;
      sticky_q   <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      op_wr_q    <= op_wr_d;
      dn_addr_q  <= dn_addr_d;
      dn_wdata_q <= dn_wdata_d;
      dn_wr_q    <= dn_wr_d;
      dn_rd_q    <= dn_rd_d;
      up_ack_q   <= up_ack_d;
      up_rdata_q <= up_rdata_d;
      wait_q     <= wait_d;
      sticky_q   <= sticky_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign up_ack         = up_ack_q;
  assign up_rdata       = up_rdata_q;
  assign dn_addr        = dn_addr_q;
  assign dn_wdata       = dn_wdata_q;
  assign dn_wr          = dn_wr_q;
  assign dn_rd          = dn_rd_q;
  assign timeout_sticky = sticky_q;
  assign timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_cfg_bus_arb.sv
// Directed self-checking bench for cfg_bus_arb (4 ports, 8-cycle timeout).
module tb_cfg_bus_arb;

  logic         clk;
  logic         sync_rst;
  logic [127:0] up_addr;
  logic [127:0] up_wdata;
  logic [3:0]   up_wr;
  logic [3:0]   up_rd;
  logic [3:0]   up_ack;
  logic [127:0] up_rdata;
  logic [31:0]  dn_addr;
  logic [31:0]  dn_wdata;
  logic         dn_wr;
  logic         dn_rd;
  logic         dn_ack;
  logic [31:0]  dn_rdata;
  logic         timeout_clr;
  logic         timeout_sticky;
  logic [15:0]  timeout_cnt;

  int total = 0;
  int bad   = 0;

  cfg_bus_arb #(
    .N_PORTS      (4),
    .TIMEOUT_CYC  (8),
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .sync_rst      (sync_rst),
    .up_addr       (up_addr),
    .up_wdata      (up_wdata),
    .up_wr         (up_wr),
    .up_rd         (up_rd),
    .up_ack        (up_ack),
    .up_rdata      (up_rdata),
    .dn_addr       (dn_addr),
    .dn_wdata      (dn_wdata),
    .dn_wr         (dn_wr),
    .dn_rd         (dn_rd),
    .dn_ack        (dn_ack),
    .dn_rdata      (dn_rdata),
    .timeout_clr   (timeout_clr),
    .timeout_sticky(timeout_sticky),
    .timeout_cnt   (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input int p);
    return up_rdata[p*32 +: 32];
  endfunction

  initial begin
    int n;
    sync_rst    = 1'b1;
    up_addr     = '0;
    up_wdata    = '0;
    up_wr       = '0;
    up_rd       = '0;
    dn_ack      = 1'b0;
    dn_rdata    = '0;
    timeout_clr = 1'b0;
    tick();
    tick();
    sync_rst = 1'b0;

    // Reset values
    chk("rst_dn_wr",  32'(dn_wr), 32'd0);
    chk("rst_dn_rd",  32'(dn_rd), 32'd0);
    chk("rst_dn_addr", dn_addr, 32'd0);
    chk("rst_up_ack", 32'(up_ack), 32'd0);
    chk("rst_up_rdata_or", 32'(|up_rdata), 32'd0);
    chk("rst_sticky", 32'(timeout_sticky), 32'd0);
    chk("rst_tcnt",   32'(timeout_cnt), 32'd0);

    // Port 2 read, immediate downstream ack: 3-cycle round trip
    up_addr[2*32 +: 32] = 32'h0000_0040;
    up_rd = 4'b0100;
    tick();
    chk("rd2_dn_rd",   32'(dn_rd), 32'd1);
    chk("rd2_dn_wr",   32'(dn_wr), 32'd0);
    chk("rd2_dn_addr", dn_addr, 32'h40);
    chk("rd2_no_ack",  32'(up_ack), 32'd0);
    dn_ack   = 1'b1;
    dn_rdata = 32'h1234_5678;
    tick();
    chk("rd2_dn_rd_off", 32'(dn_rd), 32'd0);
    chk("rd2_ack",       32'(up_ack), 32'b0100);
    chk("rd2_rdata",     rdata_of(2), 32'h1234_5678);
    dn_ack = 1'b0;
    up_rd  = '0;
    tick();
    chk("rd2_ack_pulse", 32'(up_ack), 32'd0);
    chk("rd2_rdata_hold", rdata_of(2), 32'h1234_5678);

    // Port 0 with wr and rd both high: write only, single ack, rdata 0
    up_addr[0 +: 32]  = 32'h0000_0010;
    up_wdata[0 +: 32] = 32'h0000_A5A5;
    up_wr = 4'b0001;
    up_rd = 4'b0001;
    tick();
    chk("wr0_dn_wr",    32'(dn_wr), 32'd1);
    chk("wr0_dn_rd",    32'(dn_rd), 32'd0);
    chk("wr0_dn_addr",  dn_addr, 32'h10);
    chk("wr0_dn_wdata", dn_wdata, 32'hA5A5);
    dn_ack   = 1'b1;
    dn_rdata = 32'h7777_7777;
    tick();
    chk("wr0_ack",   32'(up_ack), 32'b0001);
    chk("wr0_rdata", rdata_of(0), 32'd0);
    dn_ack = 1'b0;
    up_wr  = '0;
    up_rd  = '0;
    tick();
    chk("wr0_ack_off1", 32'(up_ack), 32'd0);
    tick();
    chk("wr0_ack_off2", 32'(up_ack), 32'd0);
    chk("wr0_idle_dn_wr", 32'(dn_wr), 32'd0);

    // Round-robin from reset: all ports read continuously -> 0,1,2,3,0
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    for (int p = 0; p < 4; p++) up_addr[p*32 +: 32] = 32'h100 + 32'(p);
    up_rd = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp_p;
      exp_p = k % 4;
      tick();
      chk("rr_dn_rd",   32'(dn_rd), 32'd1);
      chk("rr_dn_addr", dn_addr, 32'h100 + 32'(exp_p));
      dn_ack   = 1'b1;
      dn_rdata = 32'hA000_0000 + 32'(k);
      tick();
      chk("rr_ack",      32'(up_ack), 32'd1 << exp_p);
      chk("rr_dn_rd_off", 32'(dn_rd), 32'd0);
      chk("rr_rdata",    rdata_of(exp_p), 32'hA000_0000 + 32'(k));
      dn_ack = 1'b0;
      tick();
    end
    up_rd = '0;
    tick();

    // Port 1 write, never acked: 8-cycle timeout
    up_addr[1*32 +: 32]  = 32'h20;
    up_wdata[1*32 +: 32] = 32'h55;
    up_wr = 4'b0010;
    tick();
    n = 0;
    while (dn_wr && n < 20) begin
      n++;
      tick();
    end
    chk("to1_dn_wr_cycles", 32'(n), 32'd8);
    chk("to1_ack",    32'(up_ack), 32'b0010);
    chk("to1_rdata",  rdata_of(1), 32'hDEAD_BEEF);
    chk("to1_sticky", 32'(timeout_sticky), 32'd1);
    chk("to1_tcnt",   32'(timeout_cnt), 32'd1);
    up_wr = '0;
    tick();
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("clr_sticky", 32'(timeout_sticky), 32'd0);
    chk("clr_tcnt",   32'(timeout_cnt), 32'd1);

    // Port 3 read timeout with timeout_clr held high: set wins
    up_addr[3*32 +: 32] = 32'h30;
    up_rd = 4'b1000;
    timeout_clr = 1'b1;
    tick();
    n = 0;
    while (dn_rd && n < 20) begin
      n++;
      tick();
    end
    chk("to3_dn_rd_cycles", 32'(n), 32'd8);
    chk("to3_ack",    32'(up_ack), 32'b1000);
    chk("to3_rdata",  rdata_of(3), 32'hDEAD_BEEF);
    chk("to3_sticky_set_wins", 32'(timeout_sticky), 32'd1);
    chk("to3_tcnt",   32'(timeout_cnt), 32'd2);
    up_rd = '0;
    tick();
    chk("to3_sticky_cleared", 32'(timeout_sticky), 32'd0);
    timeout_clr = 1'b0;

    // Port 0 read, dn_ack exactly on the expiry cycle
    up_addr[0 +: 32] = 32'h50;
    up_rd = 4'b0001;
    tick();
    for (int c = 0; c < 7; c++) tick();
    chk("exp_dn_rd_still", 32'(dn_rd), 32'd1);
    dn_ack   = 1'b1;
    dn_rdata = 32'hCAFE_0001;
    tick();
    chk("exp_ack",    32'(up_ack), 32'b0001);
    chk("exp_rdata",  rdata_of(0), 32'hCAFE_0001);
    chk("exp_tcnt",   32'(timeout_cnt), 32'd2);
    chk("exp_sticky", 32'(timeout_sticky), 32'd0);
    dn_ack = 1'b0;
    up_rd  = '0;
    tick();
    // Late ack while idle
    dn_ack = 1'b1;
    tick();
    chk("late_ack_none", 32'(up_ack), 32'd0);
    dn_ack = 1'b0;
    tick();
    chk("late_ack_none2", 32'(up_ack), 32'd0);
    chk("late_ack_dn_rd", 32'(dn_rd), 32'd0);

    // Reset mid-ISSUE; ports 1 and 3 requesting (last grant 0 -> port 1)
    up_addr[1*32 +: 32] = 32'h61;
    up_addr[3*32 +: 32] = 32'h63;
    up_addr[0 +: 32]    = 32'h60;
    up_rd = 4'b1010;
    tick();
    chk("mid_dn_rd",   32'(dn_rd), 32'd1);
    chk("mid_dn_addr", dn_addr, 32'h61);
    sync_rst = 1'b1;
    up_rd = 4'b1011;
    tick();
    chk("mid_rst_dn_rd",   32'(dn_rd), 32'd0);
    chk("mid_rst_dn_addr", dn_addr, 32'd0);
    chk("mid_rst_up_ack",  32'(up_ack), 32'd0);
    chk("mid_rst_rdata_or", 32'(|up_rdata), 32'd0);
    chk("mid_rst_tcnt",    32'(timeout_cnt), 32'd0);
    sync_rst = 1'b0;
    dn_ack = 1'b1;
    tick();
    chk("post_rst_grant0_addr", dn_addr, 32'h60);
    chk("post_rst_dn_rd", 32'(dn_rd), 32'd1);
    chk("post_rst_no_ack", 32'(up_ack), 32'd0);
    dn_rdata = 32'h0BAD_F00D;
    tick();
    chk("post_rst_ack", 32'(up_ack), 32'b0001);
    chk("post_rst_rdata", rdata_of(0), 32'h0BAD_F00D);
    dn_ack = 1'b0;
    up_rd  = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
